branch_predictor: RTL and testbench

- Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer (BTB) plus a 2-bit saturating counter per entry.
- Looks up PC_F each cycle and produces Predict_Taken_F / Predict_Target_F.
- Predict_Taken_F travels down the pipeline as Predict_Taken_E, where the hazard control unit compares it against Branch_Taken_E to flush on mispredict.
- Trained from the execute stage; also keeps branch and mispredict performance counters.

---
 rtl/branch_predictor_pkg.sv | 22 ++
 rtl/branch_counter_update.sv | 19 +
 rtl/branch_predictor.sv | 75 +++++++
 tb/tb_branch_predictor.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types and constants for the fetch-stage branch predictor
package branch_predictor_pkg;

  localparam int BTB_ENTRIES_DEFAULT = 64;
  // Tag field sized for the smallest legal table (4 entries); larger tables zero-extend.
  localparam int TAG_W_MAX = 28;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    ctr_e                 ctr;
    logic [31:0]          target;
  } btb_entry_t;

endpackage

// File: rtl/branch_counter_update.sv
// rtl/branch_counter_update.sv - 2-bit saturating direction counter next-state function
module branch_counter_update
  import branch_predictor_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  output ctr_e next_ctr
);

  always_comb begin
    next_ctr = ctr;
    if (taken) begin
      if (ctr != STRONG_T) next_ctr = ctr_e'(logic'(1'b0) ? 2'b00 : (ctr + 2'd1));
    end else begin
      if (ctr != STRONG_NT) next_ctr = ctr_e'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters and branch/mispredict perf counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC_F,
  output logic        Predict_Taken_F,
  output logic [31:0] Predict_Target_F,
  input  logic        Branch_E,
  input  logic [31:0] PC_E,
  input  logic        Branch_Taken_E,
  input  logic [31:0] Branch_Target_E,
  input  logic        Predict_Taken_E,
  output logic [31:0] Branch_Count,
  output logic [31:0] Mispredict_Count
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  btb_entry_t btb_q [BTB_ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  btb_entry_t       f_entry, e_entry;
  logic             f_hit, e_hit;
  ctr_e             e_next_ctr;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{PC_F[1:0], PC_E[1:0]};

  assign f_idx   = PC_F[IDX_W+1:2];
  assign f_tag   = PC_F[31:IDX_W+2];
  assign f_entry = btb_q[f_idx];
  assign f_hit   = f_entry.valid && (f_entry.tag == TAG_W_MAX'(f_tag));

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign Predict_Taken_F  = f_hit && f_entry.ctr[1];
  assign Predict_Target_F = Predict_Taken_F ? f_entry.target : 32'h0;

  assign e_idx   = PC_E[IDX_W+1:2];
  assign e_tag   = PC_E[31:IDX_W+2];
  assign e_entry = btb_q[e_idx];
  assign e_hit   = e_entry.valid && (e_entry.tag == TAG_W_MAX'(e_tag));

  branch_counter_update u_ctr_update (
    .ctr      (e_entry.ctr),
    .taken    (Branch_Taken_E),
    .next_ctr (e_next_ctr)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, ctr: WEAK_NT, target: 32'h0};
      end
      Branch_Count     <= 32'h0;
      Mispredict_Count <= 32'h0;
    end else if (Branch_E) begin
      Branch_Count <= Branch_Count + 32'd1;
      if (Branch_Taken_E != Predict_Taken_E) Mispredict_Count <= Mispredict_Count + 32'd1;
      if (e_hit) begin
        btb_q[e_idx].ctr <= e_next_ctr;
        if (Branch_Taken_E) btb_q[e_idx].target <= Branch_Target_E;
      end else if (Branch_Taken_E) begin
        // Taken miss evicts whatever lived at this index, aliased or not.
        btb_q[e_idx] <= '{valid: 1'b1, tag: TAG_W_MAX'(e_tag), ctr: WEAK_T, target: Branch_Target_E};
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor and branch_counter_update
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        predict_taken_f;
  logic [31:0] predict_target_f;
  logic        branch_e;
  logic [31:0] pc_e;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic        predict_taken_e;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  ctr_e        uc_ctr;
  logic        uc_taken;
  ctr_e        uc_next;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor #(.BTB_ENTRIES(64)) dut (
    .CLK              (clk),
    .RST              (rst),
    .PC_F             (pc_f),
    .Predict_Taken_F  (predict_taken_f),
    .Predict_Target_F (predict_target_f),
    .Branch_E         (branch_e),
    .PC_E             (pc_e),
    .Branch_Taken_E   (branch_taken_e),
    .Branch_Target_E  (branch_target_e),
    .Predict_Taken_E  (predict_taken_e),
    .Branch_Count     (branch_count),
    .Mispredict_Count (mispredict_count)
  );

  branch_counter_update u_unit (
    .ctr      (uc_ctr),
    .taken    (uc_taken),
    .next_ctr (uc_next)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] ctr;
    logic       taken;
    logic [1:0] exp;
  } ctr_vec_t;

  typedef struct {
    logic        be;
    logic [31:0] pce;
    logic        tk;
    logic [31:0] tgt;
    logic        pe;
    logic [31:0] chk_pc;
    logic        exp_tk;
    logic [31:0] exp_tgt;
    logic [31:0] exp_bc;
    logic [31:0] exp_mc;
  } vec_t;

  // Reference model: per-index arrays with plain integer counter arithmetic.
  bit          m_valid [64];
  int unsigned m_tag   [64];
  int          m_ctr   [64];
  logic [31:0] m_tgt   [64];
  logic [31:0] m_bc, m_mc;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[7:2]] && (m_tag[pc[7:2]] == int'(pc[31:8]));
  endfunction

  function automatic void model_update(input logic be, input logic [31:0] pc, input logic tk,
                                       input logic [31:0] tgt, input logic pe);
    int i;
    if (!be) return;
    i = int'(pc[7:2]);
    m_bc = m_bc + 1;
    if (tk != pe) m_mc = m_mc + 1;
    if (model_hit(pc)) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1; m_tag[i] = int'(pc[31:8]); m_ctr[i] = 2; m_tgt[i] = tgt;
    end
  endfunction

  task automatic idle_inputs();
    branch_e = 0; pc_e = 0; branch_taken_e = 0; branch_target_e = 0; predict_taken_e = 0;
  endtask

  ctr_vec_t cvecs [8];
  vec_t     vecs  [15];

  initial begin
    rst = 1; pc_f = 0;
    idle_inputs();
    uc_ctr = WEAK_NT; uc_taken = 0;

    cvecs[0] = '{2'b00, 1'b0, 2'b00};
    cvecs[1] = '{2'b00, 1'b1, 2'b01};
    cvecs[2] = '{2'b01, 1'b0, 2'b00};
    cvecs[3] = '{2'b01, 1'b1, 2'b10};
    cvecs[4] = '{2'b10, 1'b0, 2'b01};
    cvecs[5] = '{2'b10, 1'b1, 2'b11};
    cvecs[6] = '{2'b11, 1'b0, 2'b10};
    cvecs[7] = '{2'b11, 1'b1, 2'b11};

    //           be  pc_e        tk  target        pe  chk_pc        tk  target        bc  mc
    vecs[0]  = '{1, 32'h40,  1, 32'h100, 0, 32'h40,  1, 32'h100, 1,  1};
    vecs[1]  = '{1, 32'h40,  0, 32'h0,   1, 32'h40,  0, 32'h0,   2,  2};
    vecs[2]  = '{1, 32'h40,  1, 32'h104, 0, 32'h40,  1, 32'h104, 3,  3};
    vecs[3]  = '{1, 32'h40,  1, 32'h104, 1, 32'h40,  1, 32'h104, 4,  3};
    vecs[4]  = '{1, 32'h40,  1, 32'h104, 1, 32'h40,  1, 32'h104, 5,  3};
    vecs[5]  = '{1, 32'h40,  0, 32'h0,   1, 32'h40,  1, 32'h104, 6,  4};
    vecs[6]  = '{1, 32'h140, 1, 32'h200, 0, 32'h40,  0, 32'h0,   7,  5};
    vecs[7]  = '{0, 32'h0,   0, 32'h0,   0, 32'h140, 1, 32'h200, 7,  5};
    vecs[8]  = '{1, 32'h240, 0, 32'h0,   0, 32'h140, 1, 32'h200, 8,  5};
    vecs[9]  = '{0, 32'h80,  1, 32'h999, 0, 32'h80,  0, 32'h0,   8,  5};
    vecs[10] = '{1, 32'h140, 0, 32'h0,   1, 32'h140, 0, 32'h0,   9,  6};
    vecs[11] = '{1, 32'h140, 0, 32'h0,   0, 32'h140, 0, 32'h0,   10, 6};
    vecs[12] = '{1, 32'h140, 1, 32'h300, 0, 32'h140, 0, 32'h0,   11, 7};
    vecs[13] = '{1, 32'h140, 1, 32'h300, 0, 32'h140, 1, 32'h300, 12, 8};
    vecs[14] = '{0, 32'h0,   0, 32'h0,   0, 32'h143, 1, 32'h300, 12, 8};

    foreach (cvecs[i]) begin
      uc_ctr = ctr_e'(cvecs[i].ctr);
      uc_taken = cvecs[i].taken;
      #1;
      check($sformatf("ctr_update[%0d]", i), 32'(uc_next), 32'(cvecs[i].exp));
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    pc_f = 32'h40;
    #1;
    check("reset_taken", 32'(predict_taken_f), 32'h0);
    check("reset_target", predict_target_f, 32'h0);
    check("reset_bc", branch_count, 32'h0);
    check("reset_mc", mispredict_count, 32'h0);

    foreach (vecs[i]) begin
      branch_e = vecs[i].be; pc_e = vecs[i].pce; branch_taken_e = vecs[i].tk;
      branch_target_e = vecs[i].tgt; predict_taken_e = vecs[i].pe;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      pc_f = vecs[i].chk_pc;
      #1;
      check($sformatf("vec%0d_taken", i), 32'(predict_taken_f), 32'(vecs[i].exp_tk));
      check($sformatf("vec%0d_target", i), predict_target_f, vecs[i].exp_tgt);
      check($sformatf("vec%0d_bc", i), branch_count, vecs[i].exp_bc);
      check($sformatf("vec%0d_mc", i), mispredict_count, vecs[i].exp_mc);
    end

    // Same-cycle lookup and allocate at the same index: old contents first, new next cycle.
    pc_f = 32'h80;
    branch_e = 1; pc_e = 32'h80; branch_taken_e = 1; branch_target_e = 32'h400; predict_taken_e = 0;
    #1;
    check("same_cycle_taken", 32'(predict_taken_f), 32'h0);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    check("next_cycle_taken", 32'(predict_taken_f), 32'h1);
    check("next_cycle_target", predict_target_f, 32'h400);
    check("next_cycle_bc", branch_count, 32'd13);

    // Reset wins over a simultaneous update.
    rst = 1;
    branch_e = 1; pc_e = 32'hC0; branch_taken_e = 1; branch_target_e = 32'h500; predict_taken_e = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    idle_inputs();
    pc_f = 32'hC0;
    #1;
    check("rst_prio_c0", 32'(predict_taken_f), 32'h0);
    pc_f = 32'h80;
    #1;
    check("rst_prio_80", 32'(predict_taken_f), 32'h0);
    check("rst_prio_bc", branch_count, 32'h0);
    check("rst_prio_mc", mispredict_count, 32'h0);

    // Randomized run against the reference model, small tag/index pool to force hits and aliasing.
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic exp_tk;
      pc_f = ({$urandom_range(0, 3)} << 8) | ({$urandom_range(0, 7)} << 2) | {$urandom_range(0, 3)};
      branch_e = ($urandom_range(0, 3) != 0);
      pc_e = ({$urandom_range(0, 3)} << 8) | ({$urandom_range(0, 7)} << 2) | {$urandom_range(0, 3)};
      branch_taken_e = 1'($urandom_range(0, 1));
      branch_target_e = $urandom & 32'hFFFF_FFFC;
      predict_taken_e = 1'($urandom_range(0, 1));
      #1;
      exp_tk = model_hit(pc_f) && (m_ctr[pc_f[7:2]] >= 2);
      check($sformatf("rnd%0d_taken", cyc), 32'(predict_taken_f), 32'(exp_tk));
      check($sformatf("rnd%0d_target", cyc), predict_target_f, exp_tk ? m_tgt[pc_f[7:2]] : 32'h0);
      check($sformatf("rnd%0d_bc", cyc), branch_count, m_bc);
      check($sformatf("rnd%0d_mc", cyc), mispredict_count, m_mc);
      model_update(branch_e, pc_e, branch_taken_e, branch_target_e, predict_taken_e);
      @(posedge clk);
      @(negedge clk);
    end
    idle_inputs();
    #1;
    check("rnd_final_bc", branch_count, m_bc);
    check("rnd_final_mc", mispredict_count, m_mc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
